id_issue_stage: RTL and testbench
=================================

# id_issue_stage

Decode-and-issue stage for the scalar core: accepts 32-bit RV64 instruction words from fetch, decodes them into ALU opcodes, reads and bypasses register operands, tracks in-flight destination registers with a scoreboard, and issues into a registered output slot that drives the execute stage (`alu_opcode`, `operand_rs1`, `operand_rs2`). It sits between fetch and execute and is the sole producer of execute-stage operands.

## Interface
- `XLEN`, 64, datapath width (matches `REG_BUS`)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset: rst, synchronous, active-high
- `inst_valid_i`  in  1  fetch holds a valid instruction
- `inst_i`  in  32  instruction word
- `inst_pc_i`  in  XLEN  PC of `inst_i`
- `inst_ready_o`  out  1  stage accepts `inst_i` this cycle
- `rs1_addr_o`, `rs2_addr_o`  out  5  regfile read addresses, combinational from `inst_i`
- `rs1_data_i`, `rs2_data_i`  in  XLEN  regfile read data, same cycle
- `wb_en_i`  in  1  writeback this cycle
- `wb_addr_i`  in  5  writeback destination
- `wb_data_i`  in  XLEN  writeback data
- `flush_i`  in  1  drop held instruction
- `ex_valid_o`  out  1  output slot holds an instruction
- `ex_ready_i`  in  1  execute consumes slot this cycle
- `alu_opcode_o`  out  `ALU_OP_BUS`  ALU operation
- `operand_rs1_o`, `operand_rs2_o`  out  XLEN  operands
- `rd_addr_o`  out  5  destination register
- `rd_wen_o`  out  1  instruction writes `rd_addr_o`
- `br_target_o`  out  XLEN  PC + B-immediate (BNE only, else 0)

## Operation
- Decode (opcode/funct3/funct7):
  - ADD `0110011/000/0000000` -> `ALU_OP_ADD`, op2 = rs2, rd_wen = (rd != 0)
  - MUL `0110011/000/0000001` -> `ALU_OP_MUL`, op2 = rs2, rd_wen = (rd != 0)
  - ADDI `0010011/000` -> `ALU_OP_ADD`, op2 = sign-extended I-imm, rs2 unused
  - BNE `1100011/001` -> `ALU_OP_BNE`, rd_wen = 0, br_target = pc + sext(B-imm), wraps mod 2^XLEN
  - anything else -> `ALU_OP_NOP`, operands 0, rd_wen = 0, no register reads used
- Operand source per used rs: x0 -> 0; else if `wb_en_i && wb_addr_i == rs` -> `wb_data_i` (bypass); else regfile data.
- Scoreboard: 32 busy bits, bit 0 hardwired 0.
  - Set `busy[rd]` when an instruction with rd_wen = 1 is accepted.
  - Clear `busy[wb_addr_i]` when `wb_en_i`.
  - Same register set and cleared in one cycle: set wins.
- Hazard: any used rs with `busy[rs] = 1` and not bypassed this cycle.
- `inst_ready_o = !rst && !flush_i && !hazard && (!ex_valid_o || ex_ready_i)`. Depends on `inst_i` when `inst_valid_i` is low, but is only meaningful when it is high.
- Output slot update, in priority order:
  1. `flush_i`: `ex_valid_o` <= 0. If the slot held rd_wen = 1, clear that `busy[rd_addr_o]`. No accept.
  2. Accept: load decoded fields, `ex_valid_o` <= 1.
  3. `ex_ready_i` with no accept: `ex_valid_o` <= 0.
  4. Otherwise hold all outputs stable.
- Consume and accept in the same cycle give back-to-back issue with no bubble.

## Timing
- Reset: `ex_valid_o`, `alu_opcode_o` (= `ALU_OP_NOP`), operands, `rd_addr_o`, `rd_wen_o`, `br_target_o` all 0; scoreboard cleared; `inst_ready_o` = 0 while `rst`.
- Reset mid-operation discards the held instruction and all busy bits.
- Issue latency: 1 cycle from accept edge to `ex_valid_o`.
- Throughput: 1 instruction/cycle absent hazards and backpressure.
- A stalled output slot keeps every output bit-stable until consumed or flushed.
- Hazard release: a writeback in cycle N lets a dependent instruction be accepted in cycle N via bypass.

## Test plan
- Reset: hold `rst` 2 cycles with `inst_valid_i` = 1 -> `inst_ready_o` = 0, `ex_valid_o` = 0, opcode `ALU_OP_NOP`, busy all clear.
- ADDI x1,x0,5 then ADD x2,x1,x1 with no writeback -> ADDI issued (op2 = 5, rd 1); ADD stalls (`inst_ready_o` = 0). Drive `wb_en_i`, addr 1, data 5 -> ADD accepted that cycle with operands 5/5.
- MUL x3,x4,x5 with regfile 7 and 6, `ex_ready_i` low 3 cycles -> `ex_valid_o` held, outputs stable (`ALU_OP_MUL`, 7, 6), `inst_ready_o` = 0; raise `ex_ready_i` -> next instruction issues back-to-back.
- BNE at pc `0x8000_0000` with B-imm −8 -> `ALU_OP_BNE`, `rd_wen_o` = 0, `br_target_o` = `0x7FFF_FFF8`, no busy bit set.
- Flush while slot holds ADD x6 -> `ex_valid_o` = 0 next cycle, `busy[6]` cleared, and a following reader of x6 is not stalled. Also: unknown opcode `0x0000007F` -> `ALU_OP_NOP`, operands 0.
- Writeback to x9 in the same cycle an ADD x9 is accepted -> `busy[9]` remains 1 (set wins); a subsequent reader of x9 stalls until the next writeback to x9.

Source files
------------

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - decode, operand bypass, scoreboard and issue slot
// Decodes ADD/MUL/ADDI/BNE; everything else issues as a NOP with zero operands.
module id_issue_stage #(
  parameter int XLEN     = 64,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid_i,
  input  logic [31:0]         inst_i,
  input  logic [XLEN-1:0]     inst_pc_i,
  output logic                inst_ready_o,
  output logic [4:0]          rs1_addr_o,
  output logic [4:0]          rs2_addr_o,
  input  logic [XLEN-1:0]     rs1_data_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  input  logic                wb_en_i,
  input  logic [4:0]          wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                flush_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [ALU_OP_W-1:0] alu_opcode_o,
  output logic [XLEN-1:0]     operand_rs1_o,
  output logic [XLEN-1:0]     operand_rs2_o,
  output logic [4:0]          rd_addr_o,
  output logic                rd_wen_o,
  output logic [XLEN-1:0]     br_target_o
);

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_OP_MUL = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OP_BNE = ALU_OP_W'(3);

  logic [6:0]          w_opc;
  logic [2:0]          w_f3;
  logic [6:0]          w_f7;
  logic [4:0]          w_rd, w_rs1, w_rs2;
  logic                w_is_add, w_is_mul, w_is_addi, w_is_bne;
  logic                w_use_rs1, w_use_rs2;
  logic                w_byp1, w_byp2, w_hazard, w_accept;
  logic [XLEN-1:0]     w_rs1_val, w_rs2_val, w_imm_i, w_imm_b;
  logic [ALU_OP_W-1:0] w_dec_op;
  logic [XLEN-1:0]     w_dec_op1, w_dec_op2, w_dec_br;
  logic [4:0]          w_dec_rd;
  logic                w_dec_wen;
  logic [31:0]         w_busy_nxt;

  logic                r_valid;
  logic [ALU_OP_W-1:0] r_op;
  logic [XLEN-1:0]     r_op1, r_op2, r_br;
  logic [4:0]          r_rd;
  logic                r_rd_wen;
  logic [31:0]         r_busy;

  assign w_opc = inst_i[6:0];
  assign w_rd  = inst_i[11:7];
  assign w_f3  = inst_i[14:12];
  assign w_rs1 = inst_i[19:15];
  assign w_rs2 = inst_i[24:20];
  assign w_f7  = inst_i[31:25];

  assign w_is_add  = (w_opc == 7'b0110011) && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
  assign w_is_mul  = (w_opc == 7'b0110011) && (w_f3 == 3'b000) && (w_f7 == 7'b0000001);
  assign w_is_addi = (w_opc == 7'b0010011) && (w_f3 == 3'b000);
  assign w_is_bne  = (w_opc == 7'b1100011) && (w_f3 == 3'b001);
  assign w_use_rs1 = w_is_add || w_is_mul || w_is_addi || w_is_bne;
  assign w_use_rs2 = w_is_add || w_is_mul || w_is_bne;

  assign w_imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign w_imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  assign rs1_addr_o = w_rs1;
  assign rs2_addr_o = w_rs2;

  // A writeback this cycle both supplies the value and hides the busy bit it is about to clear.
  assign w_byp1    = wb_en_i && (wb_addr_i == w_rs1) && (w_rs1 != 5'd0);
  assign w_byp2    = wb_en_i && (wb_addr_i == w_rs2) && (w_rs2 != 5'd0);
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : (w_byp1 ? wb_data_i : rs1_data_i);
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : (w_byp2 ? wb_data_i : rs2_data_i);
  assign w_hazard  = (w_use_rs1 && r_busy[w_rs1] && !w_byp1) ||
                     (w_use_rs2 && r_busy[w_rs2] && !w_byp2);

  assign inst_ready_o = !rst && !flush_i && !w_hazard && (!r_valid || ex_ready_i);
  assign w_accept     = inst_valid_i && inst_ready_o;

  always_comb begin
    w_dec_op  = ALU_OP_NOP;
    w_dec_op1 = '0;
    w_dec_op2 = '0;
    w_dec_rd  = 5'd0;
    w_dec_wen = 1'b0;
    w_dec_br  = '0;
    if (w_is_add || w_is_mul) begin
      w_dec_op  = w_is_mul ? ALU_OP_MUL : ALU_OP_ADD;
      w_dec_op1 = w_rs1_val;
      w_dec_op2 = w_rs2_val;
      w_dec_rd  = w_rd;
      w_dec_wen = (w_rd != 5'd0);
    end else if (w_is_addi) begin
      w_dec_op  = ALU_OP_ADD;
      w_dec_op1 = w_rs1_val;
      w_dec_op2 = w_imm_i;
      w_dec_rd  = w_rd;
      w_dec_wen = (w_rd != 5'd0);
    end else if (w_is_bne) begin
      w_dec_op  = ALU_OP_BNE;
      w_dec_op1 = w_rs1_val;
      w_dec_op2 = w_rs2_val;
      w_dec_br  = inst_pc_i + w_imm_b;
    end
  end

  // Clears first, then the accept's set, so a same-cycle set on the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en_i) w_busy_nxt[wb_addr_i] = 1'b0;
    if (flush_i && r_valid && r_rd_wen) w_busy_nxt[r_rd] = 1'b0;
    if (w_accept && w_dec_wen) w_busy_nxt[w_dec_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_op     <= ALU_OP_NOP;
      r_op1    <= '0;
      r_op2    <= '0;
      r_rd     <= 5'd0;
      r_rd_wen <= 1'b0;
      r_br     <= '0;
      r_busy   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_op     <= w_dec_op;
        r_op1    <= w_dec_op1;
        r_op2    <= w_dec_op2;
        r_rd     <= w_dec_rd;
        r_rd_wen <= w_dec_wen;
        r_br     <= w_dec_br;
      end else if (ex_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ex_valid_o    = r_valid;
  assign alu_opcode_o  = r_op;
  assign operand_rs1_o = r_op1;
  assign operand_rs2_o = r_op2;
  assign rd_addr_o     = r_rd;
  assign rd_wen_o      = r_rd_wen;
  assign br_target_o   = r_br;

endmodule

// File: tb/tb_id_issue_stage.sv
// tb/tb_id_issue_stage.sv - directed vector bench for id_issue_stage
module tb_id_issue_stage;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_BNE = 4'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic [63:0] inst_pc_i;
  logic        inst_ready_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [63:0] rs1_data_i, rs2_data_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [63:0] wb_data_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [3:0]  alu_opcode_o;
  logic [63:0] operand_rs1_o, operand_rs2_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;
  logic [63:0] br_target_o;

  id_issue_stage dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_pc_i(inst_pc_i),
    .inst_ready_o(inst_ready_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .alu_opcode_o(alu_opcode_o), .operand_rs1_o(operand_rs1_o),
    .operand_rs2_o(operand_rs2_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o),
    .br_target_o(br_target_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, d1, d2;
    logic [3:0]  op;
    logic [63:0] o1, o2;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] br;
  } vec_t;

  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_bne(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [255:0] pack(input logic [3:0] op, input logic [63:0] o1,
                                        input logic [63:0] o2, input logic [4:0] rd,
                                        input logic wen, input logic [63:0] br);
    return {50'd0, op, o1, o2, rd, wen, br};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [63:0] pc,
                         input logic [63:0] d1, input logic [63:0] d2);
    inst_valid_i = 1'b1;
    inst_i       = inst;
    inst_pc_i    = pc;
    rs1_data_i   = d1;
    rs2_data_i   = d2;
    #1;
  endtask

  function automatic logic [255:0] outs();
    return pack(alu_opcode_o, operand_rs1_o, operand_rs2_o, rd_addr_o, rd_wen_o, br_target_o);
  endfunction

  logic [255:0] held;

  initial begin
    vecs[0] = '{enc_r(7'h00, 5'd12, 5'd11, 3'd0, 5'd10, 7'b0110011), 64'h0, 64'd100, 64'd23,
                OP_ADD, 64'd100, 64'd23, 5'd10, 1'b1, 64'h0};
    vecs[1] = '{enc_r(7'h01, 5'd15, 5'd14, 3'd0, 5'd13, 7'b0110011), 64'h0, 64'd7, 64'd6,
                OP_MUL, 64'd7, 64'd6, 5'd13, 1'b1, 64'h0};
    vecs[2] = '{enc_i(12'hFFF, 5'd17, 5'd16), 64'h0, 64'd10, 64'hDEAD,
                OP_ADD, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 1'b1, 64'h0};
    vecs[3] = '{enc_r(7'h00, 5'd18, 5'd0, 3'd0, 5'd0, 7'b0110011), 64'h0, 64'd55, 64'd9,
                OP_ADD, 64'd0, 64'd9, 5'd0, 1'b0, 64'h0};
    vecs[4] = '{enc_bne(13'd16, 5'd20, 5'd19), 64'h1000, 64'd3, 64'd4,
                OP_BNE, 64'd3, 64'd4, 5'd0, 1'b0, 64'h1010};
    vecs[5] = '{32'h0000_007F, 64'h0, 64'h1111, 64'h2222,
                OP_NOP, 64'd0, 64'd0, 5'd0, 1'b0, 64'h0};
    vecs[6] = '{enc_bne(13'h1FFC, 5'd22, 5'd21), 64'h0, 64'd1, 64'd2,
                OP_BNE, 64'd1, 64'd2, 5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[7] = '{enc_i(12'h7FF, 5'd0, 5'd23), 64'h0, 64'd77, 64'd0,
                OP_ADD, 64'd0, 64'h7FF, 5'd23, 1'b1, 64'h0};
    vecs[8] = '{enc_r(7'h02, 5'd25, 5'd24, 3'd0, 5'd26, 7'b0110011), 64'h0, 64'd5, 64'd5,
                OP_NOP, 64'd0, 64'd0, 5'd0, 1'b0, 64'h0};
    vecs[9] = '{enc_r(7'h00, 5'd25, 5'd24, 3'd1, 5'd27, 7'b0110011), 64'h0, 64'd5, 64'd5,
                OP_NOP, 64'd0, 64'd0, 5'd0, 1'b0, 64'h0};

    rst = 1'b1; inst_valid_i = 1'b1; inst_i = vecs[0].inst; inst_pc_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    flush_i = 1'b0; ex_ready_i = 1'b1;

    // Reset held two cycles with a valid instruction offered.
    tick();
    chk("rst_ready_c1", {255'd0, inst_ready_o}, 256'd0);
    tick();
    chk("rst_ready_c2", {255'd0, inst_ready_o}, 256'd0);
    chk("rst_valid", {255'd0, ex_valid_o}, 256'd0);
    chk("rst_outs", outs(), pack(OP_NOP, 64'd0, 64'd0, 5'd0, 1'b0, 64'd0));
    chk("rst_busy", {224'd0, dut.r_busy}, 256'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 10; i++) begin
      present(vecs[i].inst, vecs[i].pc, vecs[i].d1, vecs[i].d2);
      chk($sformatf("vec%0d_ready", i), {255'd0, inst_ready_o}, 256'd1);
      tick();
      chk($sformatf("vec%0d_valid", i), {255'd0, ex_valid_o}, 256'd1);
      chk($sformatf("vec%0d_outs", i), outs(),
          pack(vecs[i].op, vecs[i].o1, vecs[i].o2, vecs[i].rd, vecs[i].wen, vecs[i].br));
    end
    chk("table_busy", {224'd0, dut.r_busy}, {224'd0, 32'h0081_2400});

    // Reset mid-operation drops the held slot and every busy bit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", {255'd0, ex_valid_o}, 256'd0);
    chk("midrst_busy", {224'd0, dut.r_busy}, 256'd0);

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1 released by same-cycle writeback.
    present(enc_i(12'd5, 5'd0, 5'd1), 64'h0, 64'd0, 64'd0);
    chk("addi_ready", {255'd0, inst_ready_o}, 256'd1);
    tick();
    chk("addi_outs", outs(), pack(OP_ADD, 64'd0, 64'd5, 5'd1, 1'b1, 64'd0));
    present(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2, 7'b0110011), 64'h0, 64'd0, 64'd0);
    chk("haz_stall1", {255'd0, inst_ready_o}, 256'd0);
    tick();
    chk("haz_drained", {255'd0, ex_valid_o}, 256'd0);
    chk("haz_stall2", {255'd0, inst_ready_o}, 256'd0);
    wb_en_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 64'd5;
    #1;
    chk("haz_release", {255'd0, inst_ready_o}, 256'd1);
    tick();
    wb_en_i = 1'b0;
    chk("haz_add_outs", outs(), pack(OP_ADD, 64'd5, 64'd5, 5'd2, 1'b1, 64'd0));

    // MUL held under backpressure, then back-to-back issue.
    inst_valid_i = 1'b0;
    tick();
    chk("mul_pre_empty", {255'd0, ex_valid_o}, 256'd0);
    ex_ready_i = 1'b0;
    present(enc_r(7'h01, 5'd5, 5'd4, 3'd0, 5'd3, 7'b0110011), 64'h0, 64'd7, 64'd6);
    tick();
    chk("mul_outs", outs(), pack(OP_MUL, 64'd7, 64'd6, 5'd3, 1'b1, 64'd0));
    held = outs();
    present(enc_i(12'd1, 5'd0, 5'd7), 64'h0, 64'hAA, 64'hBB);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_ready", c), {255'd0, inst_ready_o}, 256'd0);
      tick();
      chk($sformatf("stall%0d_valid", c), {255'd0, ex_valid_o}, 256'd1);
      chk($sformatf("stall%0d_outs", c), outs(), held);
    end
    ex_ready_i = 1'b1;
    #1;
    chk("b2b_ready", {255'd0, inst_ready_o}, 256'd1);
    tick();
    chk("b2b_valid", {255'd0, ex_valid_o}, 256'd1);
    chk("b2b_outs", outs(), pack(OP_ADD, 64'd0, 64'd1, 5'd7, 1'b1, 64'd0));

    // BNE with negative offset; no destination, no busy bit.
    present(enc_bne(13'h1FF8, 5'd0, 5'd0), 64'h8000_0000, 64'd0, 64'd0);
    tick();
    chk("bne_outs", outs(), pack(OP_BNE, 64'd0, 64'd0, 5'd0, 1'b0, 64'h7FFF_FFF8));
    chk("bne_busy", {224'd0, dut.r_busy}, {224'd0, 32'h0000_008C});

    // Flush of a held ADD x6 returns its busy bit.
    present(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011), 64'h0, 64'd0, 64'd0);
    tick();
    ex_ready_i = 1'b0;
    chk("flush_pre_outs", outs(), pack(OP_ADD, 64'd0, 64'd0, 5'd6, 1'b1, 64'd0));
    flush_i = 1'b1;
    present(enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd8, 7'b0110011), 64'h0, 64'h66, 64'd0);
    chk("flush_ready", {255'd0, inst_ready_o}, 256'd0);
    tick();
    flush_i = 1'b0;
    chk("flush_valid", {255'd0, ex_valid_o}, 256'd0);
    chk("flush_busy6", {255'd0, dut.r_busy[6]}, 256'd0);
    #1;
    chk("postflush_ready", {255'd0, inst_ready_o}, 256'd1);
    tick();
    chk("postflush_outs", outs(), pack(OP_ADD, 64'h66, 64'd0, 5'd8, 1'b1, 64'd0));
    ex_ready_i = 1'b1;

    // Writeback to x9 coinciding with ADD x9 accept: set wins.
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 64'h99;
    present(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'b0110011), 64'h0, 64'd0, 64'd0);
    chk("setwin_ready", {255'd0, inst_ready_o}, 256'd1);
    tick();
    wb_en_i = 1'b0;
    chk("setwin_busy9", {255'd0, dut.r_busy[9]}, 256'd1);
    present(enc_r(7'h00, 5'd0, 5'd9, 3'd0, 5'd10, 7'b0110011), 64'h0, 64'd0, 64'd0);
    chk("x9_stall1", {255'd0, inst_ready_o}, 256'd0);
    tick();
    chk("x9_stall2", {255'd0, inst_ready_o}, 256'd0);
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 64'h1234;
    #1;
    chk("x9_release", {255'd0, inst_ready_o}, 256'd1);
    tick();
    wb_en_i = 1'b0; inst_valid_i = 1'b0;
    chk("x9_outs", outs(), pack(OP_ADD, 64'h1234, 64'd0, 5'd10, 1'b1, 64'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
